// File: rtl/gate4_selftest_if.sv
// gate4_selftest_if
//   Signal bundle between the 4-input OR/NOR self-tester and its environment
//   (gate under test plus whoever issues START and reads the results).
//
//   Protocol: START is a level sampled on rising CLK edges and accepted only
//   when the tester is idle or finished (BUSY=0). An accepted START clears all
//   results and raises BUSY on the same edge. BUSY stays high until the run
//   ends. On that edge BUSY drops and DONE rises together with exactly one of
//   PASS/FAIL. DONE and the results then stay stable until the next accepted
//   START.
//
//   Modports
//     master : the tester (drives STIM and the result signals)
//     slave  : the environment (drives START and the gate responses)
interface gate4_selftest_if;
  logic       START;
  logic [3:0] STIM;
  logic       RESP_OR;
  logic       RESP_NOR;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic       FAIL;
  logic [3:0] FAIL_VEC;
  logic       FAIL_KIND;
  logic [4:0] VEC_CNT;

  modport master (
    input  START, RESP_OR, RESP_NOR,
    output STIM, BUSY, DONE, PASS, FAIL, FAIL_VEC, FAIL_KIND, VEC_CNT
  );

  modport slave (
    output START, RESP_OR, RESP_NOR,
    input  STIM, BUSY, DONE, PASS, FAIL, FAIL_VEC, FAIL_KIND, VEC_CNT
  );
endinterface

// File: rtl/gate4_selftest.sv
// gate4_selftest
//   Exhaustive self-test for a 4-input OR/NOR gate. On START it walks STIM
//   through 0..15, holding each value SETTLE cycles, then compares RESP_OR
//   against |STIM and RESP_NOR against ~|STIM. The first mismatch stops the
//   run and records the vector and which output was wrong; a clean pass over
//   all 16 vectors reports PASS.
//
//   Protocol: START is a level sampled on rising CLK edges and accepted only
//   in IDLE or END. An accepted START clears all results and raises BUSY on
//   the same edge. BUSY stays high until the run ends; on that edge BUSY drops
//   and DONE rises with exactly one of PASS/FAIL, and all results then stay
//   stable until the next accepted START.
//
//   Parameters
//     SETTLE     cycles each vector is held before sampling (1..15)
//   Ports
//     CLK        clock, rising edge
//     RST_N      asynchronous active-low reset
//     START      run request
//     STIM       stimulus to the gate, bit n drives input In
//     RESP_OR    gate OR output
//     RESP_NOR   gate NOR output
//     BUSY       run in progress
//     DONE       run finished (sticky until next START)
//     PASS       all 16 vectors matched (with DONE)
//     FAIL       a mismatch stopped the run (with DONE)
//     FAIL_VEC   vector at the first mismatch
//     FAIL_KIND  0 = OR mismatch, 1 = NOR mismatch
//     VEC_CNT    vectors checked and matched so far
//     state_dbg  current FSM state (0 IDLE, 1 RUN, 2 END)
module gate4_selftest #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic [3:0] STIM,
  input  logic       RESP_OR,
  input  logic       RESP_NOR,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic       FAIL,
  output logic [3:0] FAIL_VEC,
  output logic       FAIL_KIND,
  output logic [4:0] VEC_CNT,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_e     state_q,     state_d;
  logic [3:0] settle_q,    settle_d;
  logic [3:0] stim_q,      stim_d;
  logic       fail_q,      fail_d;
  logic [3:0] fail_vec_q,  fail_vec_d;
  logic       fail_kind_q, fail_kind_d;
  logic [4:0] vec_cnt_q,   vec_cnt_d;

  logic exp_or;
  logic or_bad;
  logic nor_bad;

  // Case-inequality so an X or Z response counts as a mismatch rather than
  // silently comparing as unknown.
  always_comb begin
    exp_or  = |stim_q;
    or_bad  = (RESP_OR  !== exp_or);
    nor_bad = (RESP_NOR !== ~exp_or);
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      settle_q    <= 4'd0;
      stim_q      <= 4'd0;
      fail_q      <= 1'b0;
      fail_vec_q  <= 4'd0;
      fail_kind_q <= 1'b0;
      vec_cnt_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      stim_q      <= stim_d;
      fail_q      <= fail_d;
      fail_vec_q  <= fail_vec_d;
      fail_kind_q <= fail_kind_d;
      vec_cnt_q   <= vec_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    stim_d      = stim_q;
    fail_d      = fail_q;
    fail_vec_d  = fail_vec_q;
    fail_kind_d = fail_kind_q;
    vec_cnt_d   = vec_cnt_q;

    unique case (state_q)
      ST_IDLE, ST_END: begin
        if (START) begin
          state_d     = ST_RUN;
          settle_d    = SETTLE_LD;
          stim_d      = 4'd0;
          fail_d      = 1'b0;
          fail_vec_d  = 4'd0;
          fail_kind_d = 1'b0;
          vec_cnt_d   = 5'd0;
        end
      end

      ST_RUN: begin
        // settle_q == 1 marks the last hold cycle: the response is sampled
        // on this edge, SETTLE edges after the vector was applied.
        if (settle_q == 4'd1) begin
          if (or_bad || nor_bad) begin
            state_d     = ST_END;
            settle_d    = 4'd0;
            fail_d      = 1'b1;
            fail_vec_d  = stim_q;
            fail_kind_d = ~or_bad;    // OR wins when both are wrong
          end else begin
            vec_cnt_d = vec_cnt_q + 5'd1;
            if (stim_q == 4'd15) begin
              state_d  = ST_END;      // STIM stays at 15
              settle_d = 4'd0;
            end else begin
              stim_d   = stim_q + 4'd1;
              settle_d = SETTLE_LD;
            end
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: BUSY/DONE follow the state, so they can never overlap.
  always_comb begin
    BUSY      = (state_q == ST_RUN);
    DONE      = (state_q == ST_END);
    PASS      = DONE & ~fail_q;
    FAIL      = DONE &  fail_q;
    STIM      = stim_q;
    FAIL_VEC  = fail_vec_q;
    FAIL_KIND = fail_kind_q;
    VEC_CNT   = vec_cnt_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_gate4_selftest.sv
// tb_gate4_selftest
//   Bench for gate4_selftest. Two instances share the clock: dut_a with
//   SETTLE=1 and dut_b with SETTLE=3. Each drives a bench gate model whose
//   behaviour is selected by a mode variable. Expected end-of-run results are
//   pushed into exp_q when a run is launched; a monitor pops and compares
//   whenever a DONE rising edge is observed.
module tb_gate4_selftest;

  localparam int MODE_OK       = 0;
  localparam int MODE_OR_SA0   = 1;
  localparam int MODE_NOR_SA0  = 2;
  localparam int MODE_SWAP     = 3;
  localparam int MODE_XSETTLE  = 4;

  // Result word: {PASS, FAIL, FAIL_VEC[3:0], FAIL_KIND, VEC_CNT[4:0], STIM[3:0]}
  localparam logic [15:0] MASK_ALL     = 16'hFFFF;
  localparam logic [15:0] MASK_NO_KIND = 16'hFDFF;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_a, dbg_b;

  int checks = 0;
  int errors = 0;

  int mode_a = MODE_OK;
  int mode_b = MODE_OK;
  int cur_sel = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mask_q[$];

  gate4_selftest_if if_a();
  gate4_selftest_if if_b();

  gate4_selftest #(.SETTLE(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(if_a.START), .STIM(if_a.STIM),
    .RESP_OR(if_a.RESP_OR), .RESP_NOR(if_a.RESP_NOR), .BUSY(if_a.BUSY),
    .DONE(if_a.DONE), .PASS(if_a.PASS), .FAIL(if_a.FAIL),
    .FAIL_VEC(if_a.FAIL_VEC), .FAIL_KIND(if_a.FAIL_KIND),
    .VEC_CNT(if_a.VEC_CNT), .state_dbg(dbg_a)
  );

  gate4_selftest #(.SETTLE(3)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(if_b.START), .STIM(if_b.STIM),
    .RESP_OR(if_b.RESP_OR), .RESP_NOR(if_b.RESP_NOR), .BUSY(if_b.BUSY),
    .DONE(if_b.DONE), .PASS(if_b.PASS), .FAIL(if_b.FAIL),
    .FAIL_VEC(if_b.FAIL_VEC), .FAIL_KIND(if_b.FAIL_KIND),
    .VEC_CNT(if_b.VEC_CNT), .state_dbg(dbg_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- gate models ----------------
  // age counts falling edges since the last STIM change or run start; the
  // slow gate reports X until two cycles have passed.
  int   age_a = 0, age_b = 0;
  logic [3:0] last_stim_a = 4'd0, last_stim_b = 4'd0;
  logic last_busy_a = 1'b0, last_busy_b = 1'b0;

  always @(negedge clk) begin
    if (if_a.STIM != last_stim_a || (if_a.BUSY && !last_busy_a)) age_a = 0;
    else if (age_a < 3) age_a++;
    last_stim_a = if_a.STIM;
    last_busy_a = if_a.BUSY;
    if (if_b.STIM != last_stim_b || (if_b.BUSY && !last_busy_b)) age_b = 0;
    else if (age_b < 3) age_b++;
    last_stim_b = if_b.STIM;
    last_busy_b = if_b.BUSY;
  end

  always_comb begin
    if_a.RESP_OR  = |if_a.STIM;
    if_a.RESP_NOR = ~|if_a.STIM;
    case (mode_a)
      MODE_OR_SA0:  if_a.RESP_OR  = 1'b0;
      MODE_NOR_SA0: if_a.RESP_NOR = 1'b0;
      MODE_SWAP: begin
        if_a.RESP_OR  = ~|if_a.STIM;
        if_a.RESP_NOR = |if_a.STIM;
      end
      MODE_XSETTLE: if (age_a < 2) begin
        if_a.RESP_OR  = 1'bx;
        if_a.RESP_NOR = 1'bx;
      end
      default: ;
    endcase
  end

  always_comb begin
    if_b.RESP_OR  = |if_b.STIM;
    if_b.RESP_NOR = ~|if_b.STIM;
    if (mode_b == MODE_XSETTLE && age_b < 2) begin
      if_b.RESP_OR  = 1'bx;
      if_b.RESP_NOR = 1'bx;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] pack(input logic p, input logic f,
                                       input logic [3:0] v, input logic k,
                                       input logic [4:0] c, input logic [3:0] s);
    return {p, f, v, k, c, s};
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] res_a, res_b, res_s;
  logic busy_s, done_s;
  logic [3:0] stim_s;
  logic [1:0] dbg_s;

  always_comb begin
    res_a = pack(if_a.PASS, if_a.FAIL, if_a.FAIL_VEC, if_a.FAIL_KIND, if_a.VEC_CNT, if_a.STIM);
    res_b = pack(if_b.PASS, if_b.FAIL, if_b.FAIL_VEC, if_b.FAIL_KIND, if_b.VEC_CNT, if_b.STIM);
    res_s  = (cur_sel == 1) ? res_b : res_a;
    busy_s = (cur_sel == 1) ? if_b.BUSY : if_a.BUSY;
    done_s = (cur_sel == 1) ? if_b.DONE : if_a.DONE;
    stim_s = (cur_sel == 1) ? if_b.STIM : if_a.STIM;
    dbg_s  = (cur_sel == 1) ? dbg_b : dbg_a;
  end

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) if_b.START = v;
    else          if_a.START = v;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic done_prev_a = 1'b0, done_prev_b = 1'b0;

  task automatic sb_pop(input string who, input logic [15:0] act,
                        input logic busy, input logic pass, input logic fail);
    logic [15:0] e, m;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done: got result %h expected no DONE", who, act);
    end else begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      check({who, "_result"}, act & m, e & m);
      check({who, "_pass_and_fail"}, {15'd0, pass & fail}, 16'd0);
      check({who, "_done_and_busy"}, {15'd0, busy}, 16'd0);
    end
  endtask

  always @(negedge clk) begin
    if (if_a.DONE && !done_prev_a)
      sb_pop("dut_a", res_a, if_a.BUSY, if_a.PASS, if_a.FAIL);
    if (if_b.DONE && !done_prev_b)
      sb_pop("dut_b", res_b, if_b.BUSY, if_b.PASS, if_b.FAIL);
    done_prev_a = if_a.DONE;
    done_prev_b = if_b.DONE;
  end

  // ---------------- run driver ----------------
  // Launches one run on the selected instance and waits (bounded) for DONE.
  // n counts rising edges since the accepting edge E0.
  task automatic run(input int sel, input logic [15:0] exp_w,
                     input logic [15:0] mask, input int exp_cycles,
                     input int settle, input bit seq_chk, input bit clr_chk);
    int n;
    cur_sel = sel;
    exp_q.push_back(exp_w);
    mask_q.push_back(mask);
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    n = 0;
    if (clr_chk) begin
      check("clear_on_start", res_s, pack(0, 0, 4'd0, 0, 5'd0, 4'd0));
      check("busy_on_start", {14'd0, done_s, busy_s}, 16'd1);
    end
    while (!done_s && n < exp_cycles + 20) begin
      if (seq_chk && busy_s) check("stim_seq", {12'd0, stim_s}, 16'(n / settle));
      @(negedge clk); n++;
    end
    check("done_seen", {15'd0, done_s}, 16'd1);
    check("run_cycles", 16'(n), 16'(exp_cycles));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    if_a.START = 1'b0;
    if_b.START = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset acts before any clock edge.
    check("reset_a", res_a, 16'd0);
    check("reset_b", res_b, 16'd0);
    check("reset_flags_a", {12'd0, if_a.BUSY, if_a.DONE, dbg_a}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct gate, full pass with stepping check.
    mode_a = MODE_OK;
    run(0, pack(1, 0, 4'd0, 0, 5'd16, 4'd15), MASK_ALL, 16, 1, 1'b1, 1'b0);
    // Held stable in END.
    repeat (3) @(negedge clk);
    check("end_hold", res_a, pack(1, 0, 4'd0, 0, 5'd16, 4'd15));

    // OR stuck at 0: fails on vector 1.
    mode_a = MODE_OR_SA0;
    run(0, pack(0, 1, 4'd1, 0, 5'd1, 4'd1), MASK_ALL, 2, 1, 1'b0, 1'b0);

    // Restart after FAIL: results cleared on accepting edge, then pass.
    mode_a = MODE_OK;
    run(0, pack(1, 0, 4'd0, 0, 5'd16, 4'd15), MASK_ALL, 16, 1, 1'b0, 1'b1);

    // NOR stuck at 0: fails on vector 0, NOR kind.
    mode_a = MODE_NOR_SA0;
    run(0, pack(0, 1, 4'd0, 1, 5'd0, 4'd0), MASK_ALL, 1, 1, 1'b0, 1'b0);

    // Swapped outputs: both wrong at vector 0, OR reported.
    mode_a = MODE_SWAP;
    run(0, pack(0, 1, 4'd0, 0, 5'd0, 4'd0), MASK_ALL, 1, 1, 1'b0, 1'b0);

    // Slow gate, SETTLE=1: fails on vector 0.
    mode_a = MODE_XSETTLE;
    run(0, pack(0, 1, 4'd0, 0, 5'd0, 4'd0), MASK_NO_KIND, 1, 1, 1'b0, 1'b0);

    // Slow gate, SETTLE=3: passes in 48 cycles.
    mode_b = MODE_XSETTLE;
    run(1, pack(1, 0, 4'd0, 0, 5'd16, 4'd15), MASK_ALL, 48, 3, 1'b1, 1'b0);

    // START re-pulsed at cycle 5 is ignored; reset at cycle 8 aborts.
    mode_a = MODE_OK;
    cur_sel = 0;
    @(negedge clk); if_a.START = 1'b1;
    @(negedge clk); if_a.START = 1'b0;
    n = 0;
    while (n < 8) begin
      check("abort_stim_seq", {12'd0, if_a.STIM}, 16'(n));
      if_a.START = (n == 5);
      @(negedge clk); n++;
    end
    if_a.START = 1'b0;
    check("pre_reset_cnt", {11'd0, if_a.VEC_CNT}, 16'd8);
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", res_a, 16'd0);
    check("reset_mid_flags", {12'd0, if_a.BUSY, if_a.DONE, dbg_a}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_abort", {12'd0, if_a.BUSY, if_a.DONE, dbg_a}, 16'd0);
    run(0, pack(1, 0, 4'd0, 0, 5'd16, 4'd15), MASK_ALL, 16, 1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate4_selftest.md
GATE4_SELFTEST -- requirements
Module: gate4_selftest

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each stimulus vector is held before its response is sampled; legal range 1..15.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port START  input  1  run request, sampled on rising CLK edges.
REQ-005 SHALL have port STIM  output  4  stimulus to the 4-input OR/NOR gate under test; bit n drives input In.
REQ-006 SHALL have port RESP_OR  input  1  OR output of the gate under test.
REQ-007 SHALL have port RESP_NOR  input  1  NOR output of the gate under test.
REQ-008 SHALL have port BUSY  output  1  high while a run is in progress.
REQ-009 SHALL have port DONE  output  1  sticky, high after a run ends (pass or fail).
REQ-010 SHALL have port PASS  output  1  high with DONE when all 16 vectors matched.
REQ-011 SHALL have port FAIL  output  1  high with DONE when a mismatch stopped the run.
REQ-012 SHALL have port FAIL_VEC  output  4  vector value at the first mismatch.
REQ-013 SHALL have port FAIL_KIND  output  1  0 = OR mismatch, 1 = NOR mismatch.
REQ-014 SHALL have port VEC_CNT  output  5  number of vectors checked and matched in the current or last run.

Function
REQ-015 SHALL implement states IDLE, RUN, END; the settle count is a 4-bit down-counter inside RUN.
REQ-016 IDLE or END with START=1 at edge E0 SHALL enter RUN, set STIM=0 and BUSY=1, clear DONE/PASS/FAIL/FAIL_VEC/FAIL_KIND/VEC_CNT, and load the settle counter with SETTLE.
REQ-017 In RUN, each STIM value SHALL be held exactly SETTLE cycles; responses SHALL be sampled at edge E0+(k+1)*SETTLE for vector k.
REQ-018 Expected values SHALL be: OR = reduction-OR of STIM; NOR = its complement.
REQ-019 Comparison SHALL treat X or Z on RESP_OR/RESP_NOR as a mismatch (case-inequality semantics).
REQ-020 On a match at vector k<15: VEC_CNT increments; STIM becomes k+1 on the same edge; the settle counter reloads.
REQ-021 On a match at vector 15: VEC_CNT=16; state END; DONE=1, PASS=1, BUSY=0 on that edge; STIM holds 15 (no wrap to 0).
REQ-022 On a mismatch: state END; DONE=1, FAIL=1, BUSY=0, FAIL_VEC=STIM; VEC_CNT is not incremented; STIM holds the failing vector.
REQ-023 If OR and NOR both mismatch at the same vector, FAIL_KIND SHALL be 0 (OR has priority).
REQ-024 START while in RUN SHALL be ignored; the run continues unchanged.
REQ-025 END SHALL hold all result outputs stable until the next accepted START.
REQ-026 PASS and FAIL SHALL never be high together; DONE and BUSY SHALL never be high together.
REQ-027 A clean run SHALL take 16*SETTLE cycles from E0 to DONE.

Reset
REQ-028 RST_N low SHALL immediately force: state IDLE; STIM=0; BUSY, DONE, PASS, FAIL, FAIL_KIND = 0; FAIL_VEC=0; VEC_CNT=0; settle counter 0. No rising CLK edge is required.
REQ-029 Reset asserted during RUN SHALL abort the run without asserting DONE; after release, the block SHALL wait in IDLE for START.
REQ-030 START SHALL not be accepted on an edge where RST_N is low.

Verification
REQ-031 Correct combinational gate model, SETTLE=1, START pulse -> STIM steps 0..15 one per cycle; 16 cycles later DONE=1, PASS=1, FAIL=0, VEC_CNT=16, STIM=15.
REQ-032 RESP_OR stuck at 0 -> DONE=1, FAIL=1, FAIL_VEC=1, FAIL_KIND=0, VEC_CNT=1.
REQ-033 RESP_NOR stuck at 0 -> FAIL at FAIL_VEC=0, FAIL_KIND=1, VEC_CNT=0; RESP_OR and RESP_NOR swapped -> FAIL_VEC=0, FAIL_KIND=0.
REQ-034 SETTLE=3, gate whose output is X for 2 cycles after each input change -> PASS=1 after 48 cycles; the same gate with SETTLE=1 -> FAIL at FAIL_VEC=0.
REQ-035 START re-pulsed at cycle 5 of a run -> no effect on STIM sequence; RST_N pulsed low at cycle 8 -> outputs zero immediately, DONE stays 0; a new START then gives a full PASS run.
REQ-036 A second START in END after a FAIL -> results cleared on the accepting edge; a correct model then gives PASS=1, FAIL=0.
